axis_burst_packetizer: RTL



---
 rtl/axis_burst_packetizer_pkg.sv | 18 +
 rtl/axis_burst_packetizer_skid.sv | 73 +++++++
 rtl/axis_burst_packetizer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axis_burst_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// axis_burst_packetizer_pkg
// Shared definitions for the burst packetizer:
//   state_e          - packetizer control state (IDLE, BURST)
//   cnt_width()      - bits needed to hold the values 0..max_val (minimum 1)
// ---------------------------------------------------------------------------
package axis_burst_packetizer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axis_burst_packetizer_skid.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Full-throughput 2-entry register slice for a valid/ready stream. The
// output register feeds the consumer; the skid register catches the one beat
// accepted while the consumer stalls. Input ready depends only on local
// state, so no combinational ready path crosses the slice.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_data/s_valid    - upstream beat, s_ready back to upstream
//   m_data/m_valid    - downstream beat, m_ready from downstream
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_fire;

    assign s_ready = !skid_valid_q;
    assign in_fire = s_valid && !skid_valid_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_ready) begin
            // Output register frees up: the skid beat is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_burst_packetizer.sv
// ---------------------------------------------------------------------------
// axis_burst_packetizer
// Pops a streaming FIFO and re-emits its words as AXI-Stream packets with a
// real TLAST. Full BURST_LEN-beat packets start once the FIFO write count
// shows enough data; a residual short packet is forced by a timeout or by a
// flush request so data is never stranded.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   S_AXIS_TDATA/TVALID/TREADY  - FIFO master side (TREADY is the pop strobe)
//   fifo_count                  - FIFO write data count (may lag, never lead)
//   flush                       - single-cycle request to drain residual data
//   M_AXIS_TDATA/TKEEP/TLAST/TVALID/TREADY - packet output stream
//   busy                        - burst in progress or output slice occupied
//   pkt_count                   - completed packets, wraps modulo 2^32
// ---------------------------------------------------------------------------
module axis_burst_packetizer
    import axis_burst_packetizer_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH    = 512,
    parameter int unsigned FIFO_DEPTH     = 512,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TDATA_WIDTH-1:0]        S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    output logic                          S_AXIS_TREADY,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          flush,
    output logic [TDATA_WIDTH-1:0]        M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]      M_AXIS_TKEEP,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          busy,
    output logic [31:0]                   pkt_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_W = cnt_width(BURST_LEN);
    localparam int unsigned CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CMP_W-1:0] BURST_LEN_C = CMP_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] TMR_MAX     = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               flush_pending_q, flush_pending_d;
    logic [31:0]        pkt_count_q, pkt_count_d;

    logic [CMP_W-1:0]   count_ext;
    logic               in_burst;
    logic               slice_s_ready;
    logic               s_fire;
    logic               last_beat;
    logic [TDATA_WIDTH:0] slice_out;

    assign count_ext = CMP_W'(fifo_count);
    assign in_burst  = (state_q == BURST);
    assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));

    assign S_AXIS_TREADY = in_burst && slice_s_ready;
    assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;

    axis_skid_buffer #(
        .WIDTH (TDATA_WIDTH + 1)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({last_beat, S_AXIS_TDATA}),
        .s_valid (S_AXIS_TVALID && in_burst),
        .s_ready (slice_s_ready),
        .m_data  (slice_out),
        .m_valid (M_AXIS_TVALID),
        .m_ready (M_AXIS_TREADY)
    );

    assign M_AXIS_TLAST = slice_out[TDATA_WIDTH];
    assign M_AXIS_TDATA = slice_out[TDATA_WIDTH-1:0];
    assign M_AXIS_TKEEP = '1;
    assign busy         = in_burst || M_AXIS_TVALID;
    assign pkt_count    = pkt_count_q;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        beat_cnt_d      = beat_cnt_q;
        len_d           = len_q;
        flush_pending_d = flush_pending_q;
        pkt_count_d     = pkt_count_q;

        if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (count_ext >= BURST_LEN_C) begin
                    // A full burst does not consume a flush request: the
                    // request still applies to whatever remains afterwards.
                    len_d           = BURST_LEN_L;
                    state_d         = BURST;
                    timer_d         = '0;
                    flush_pending_d = flush_pending_q || flush;
                end else if (count_ext != '0 &&
                             (flush_pending_q || flush || timer_q == TMR_MAX)) begin
                    // count_ext < BURST_LEN here, so it fits in LEN_W bits.
                    len_d           = count_ext[LEN_W-1:0];
                    state_d         = BURST;
                    timer_d         = '0;
                    flush_pending_d = 1'b0;
                end else if (count_ext == '0) begin
                    timer_d         = '0;
                    flush_pending_d = 1'b0;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            BURST: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (s_fire) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            beat_cnt_q      <= '0;
            len_q           <= '0;
            flush_pending_q <= 1'b0;
            pkt_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            beat_cnt_q      <= beat_cnt_d;
            len_q           <= len_d;
            flush_pending_q <= flush_pending_d;
            pkt_count_q     <= pkt_count_d;
        end
    end

endmodule
